// File: rtl/pixel_frame_writer.sv
// Purpose : turns the draw blocks' pixel-plot stream into frame-buffer writes, with full-screen clear and drop counting.
// Latency : 1 cycle from an accepted plot to its registered write; a clear emits one write per cycle.
// Backpr. : none; plots seen while busy, plots that collide with clear_start and off-screen plots are counted as drops.
//
// Ports:
//   clk, reset        - rising-edge clock, asynchronous active-high reset
//   plot, x, y        - pixel strobe and coordinate (160x120 screen)
//   colour            - pixel colour
//   clear_start       - request a full-buffer fill (ignored while busy)
//   clear_colour      - fill colour, captured with clear_start
//   mem_address/data  - registered frame-buffer write address and data
//   mem_wren          - registered frame-buffer write enable
//   busy              - high while a clear is sweeping the buffer
//   clear_done        - one-cycle pulse in the cycle after the last clear write
//   drop_count        - saturating count of discarded plots
module pixel_frame_writer #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int COLOUR_W = 9,
  parameter int ADDR_W   = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                plot,
  input  logic [7:0]          x,
  input  logic [6:0]          y,
  input  logic [COLOUR_W-1:0] colour,
  input  logic                clear_start,
  input  logic [COLOUR_W-1:0] clear_colour,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [COLOUR_W-1:0] mem_data,
  output logic                mem_wren,
  output logic                busy,
  output logic                clear_done,
  output logic [7:0]          drop_count
);

  localparam logic [7:0]        LP_W_LIM = 8'(SCREEN_W);
  localparam logic [6:0]        LP_H_LIM = 7'(SCREEN_H);
  localparam logic [ADDR_W-1:0] LP_LAST  = ADDR_W'(SCREEN_W * SCREEN_H - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [ADDR_W-1:0]   r_clr_addr;
  logic [COLOUR_W-1:0] r_clr_colour;
  logic [ADDR_W-1:0]   r_mem_address;
  logic [COLOUR_W-1:0] r_mem_data;
  logic                r_mem_wren;
  logic                r_clear_done;
  logic [7:0]          r_drop_count;

  logic [ADDR_W-1:0]   w_clr_addr_nxt;
  logic [COLOUR_W-1:0] w_clr_colour_nxt;
  logic [ADDR_W-1:0]   w_addr_nxt;
  logic [COLOUR_W-1:0] w_data_nxt;
  logic                w_wren_nxt;
  logic                w_done_nxt;
  logic                w_drop;
  logic                w_in_range;
  logic [ADDR_W-1:0]   w_pix_addr;
  logic [ADDR_W-1:0]   w_clr_inc;

  // y*160 + x as y*128 + y*32 + x; each term is zero-extended to the address width.
  assign w_pix_addr = {1'b0, y, 7'b0} + {3'b0, y, 5'b0} + {7'b0, x};
  assign w_in_range = (x < LP_W_LIM) && (y < LP_H_LIM);
  assign w_clr_inc  = r_clr_addr + ADDR_W'(1);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and next-write decode.
  always_comb begin
    w_state_nxt      = r_state;
    w_clr_addr_nxt   = r_clr_addr;
    w_clr_colour_nxt = r_clr_colour;
    w_addr_nxt       = r_mem_address;
    w_data_nxt       = r_mem_data;
    w_wren_nxt       = 1'b0;
    w_done_nxt       = 1'b0;
    w_drop           = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (clear_start) begin
          // Clear wins; the first fill write (address 0) goes out with busy's first cycle.
          w_state_nxt      = S_CLEAR;
          w_clr_addr_nxt   = '0;
          w_clr_colour_nxt = clear_colour;
          w_wren_nxt       = 1'b1;
          w_addr_nxt       = '0;
          w_data_nxt       = clear_colour;
          w_drop           = plot;
        end else if (plot) begin
          if (w_in_range) begin
            w_wren_nxt = 1'b1;
            w_addr_nxt = w_pix_addr;
            w_data_nxt = colour;
          end else begin
            w_drop = 1'b1;
          end
        end
      end

      S_CLEAR: begin
        // r_clr_addr is the address currently on the bus; plots are lost while sweeping.
        w_drop = plot;
        if (r_clr_addr == LP_LAST) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_clr_addr_nxt = w_clr_inc;
          w_wren_nxt     = 1'b1;
          w_addr_nxt     = w_clr_inc;
          w_data_nxt     = r_clr_colour;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Registered write port, clear sweep and drop accounting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clr_addr    <= '0;
      r_clr_colour  <= '0;
      r_mem_address <= '0;
      r_mem_data    <= '0;
      r_mem_wren    <= 1'b0;
      r_clear_done  <= 1'b0;
      r_drop_count  <= '0;
    end else begin
      r_clr_addr    <= w_clr_addr_nxt;
      r_clr_colour  <= w_clr_colour_nxt;
      r_mem_address <= w_addr_nxt;
      r_mem_data    <= w_data_nxt;
      r_mem_wren    <= w_wren_nxt;
      r_clear_done  <= w_done_nxt;
      if (w_drop && (r_drop_count != 8'hFF)) begin
        r_drop_count <= r_drop_count + 8'd1;
      end
    end
  end

  assign mem_address = r_mem_address;
  assign mem_data    = r_mem_data;
  assign mem_wren    = r_mem_wren;
  assign busy        = (r_state == S_CLEAR);
  assign clear_done  = r_clear_done;
  assign drop_count  = r_drop_count;

endmodule

// File: tb/tb_pixel_frame_writer.sv
// Purpose : self-checking bench for pixel_frame_writer against a cycle-level behavioural model.
// Latency : model predicts every output one cycle after the inputs it is given.
// Backpr. : n/a.
module tb_pixel_frame_writer;

  localparam int NPIX = 160 * 120;

  logic       clk = 1'b0;
  logic       reset;
  logic       plot;
  logic [7:0] x;
  logic [6:0] y;
  logic [8:0] colour;
  logic       clear_start;
  logic [8:0] clear_colour;
  logic [14:0] mem_address;
  logic [8:0]  mem_data;
  logic        mem_wren;
  logic        busy;
  logic        clear_done;
  logic [7:0]  drop_count;

  pixel_frame_writer dut (
    .clk          (clk),
    .reset        (reset),
    .plot         (plot),
    .x            (x),
    .y            (y),
    .colour       (colour),
    .clear_start  (clear_start),
    .clear_colour (clear_colour),
    .mem_address  (mem_address),
    .mem_data     (mem_data),
    .mem_wren     (mem_wren),
    .busy         (busy),
    .clear_done   (clear_done),
    .drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: spec-level state of the writer.
  bit m_busy;
  int m_cur;
  int m_col;
  int m_addr;
  int m_data;
  int m_drop;
  int fb_ref [NPIX];
  int fb_dut [NPIX];
  int busy_cycles;
  int clear_writes;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_cur = 0; m_col = 0; m_addr = 0; m_data = 0; m_drop = 0;
  endtask

  // One clock: drive inputs, advance the model, check all outputs after the edge.
  task automatic cycle(input bit p, input int px, input int py, input int pc,
                       input bit cs, input int cc);
    bit e_wren;
    bit e_done;
    plot = p; x = 8'(px); y = 7'(py); colour = 9'(pc);
    clear_start = cs; clear_colour = 9'(cc);
    e_wren = 0;
    e_done = 0;
    if (!m_busy) begin
      if (cs) begin
        if (p) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
        m_busy = 1; m_cur = 0; m_col = cc;
        e_wren = 1; m_addr = 0; m_data = cc;
      end else if (p) begin
        if (px < 160 && py < 120) begin
          e_wren = 1; m_addr = py * 160 + px; m_data = pc;
        end else begin
          m_drop = (m_drop < 255) ? m_drop + 1 : 255;
        end
      end
    end else begin
      if (p) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
      if (m_cur == NPIX - 1) begin
        m_busy = 0; e_done = 1;
      end else begin
        m_cur++; e_wren = 1; m_addr = m_cur; m_data = m_col;
      end
    end
    if (e_wren) fb_ref[m_addr] = m_data;
    @(posedge clk);
    #1;
    check("mem_wren", 32'(mem_wren), 32'(e_wren));
    check("mem_address", 32'(mem_address), 32'(m_addr));
    check("mem_data", 32'(mem_data), 32'(m_data));
    check("busy", 32'(busy), 32'(m_busy));
    check("clear_done", 32'(clear_done), 32'(e_done));
    check("drop_count", 32'(drop_count), 32'(m_drop));
    if (mem_wren && int'(mem_address) < NPIX) fb_dut[mem_address] = int'(mem_data);
    if (busy) busy_cycles++;
    if (busy && mem_wren) clear_writes++;
  endtask

  task automatic idle_cycle();
    cycle(0, 0, 0, 0, 0, 0);
  endtask

  task automatic random_plots(input int n);
    for (int i = 0; i < n; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 175), $urandom_range(0, 127),
            $urandom_range(0, 511), 0, 0);
    end
  endtask

  initial begin
    int diffs;
    int k;
    for (int i = 0; i < NPIX; i++) begin
      fb_ref[i] = 0;
      fb_dut[i] = 0;
    end
    model_reset();
    reset = 1'b1; plot = 0; x = 0; y = 0; colour = 0; clear_start = 0; clear_colour = 0;
    #3;
    check("rst_wren", 32'(mem_wren), 0);
    check("rst_addr", 32'(mem_address), 0);
    check("rst_data", 32'(mem_data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(clear_done), 0);
    check("rst_drop", 32'(drop_count), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Directed: single plot, back-to-back corner plots, off-screen drops.
    cycle(1, 0, 0, 9'h1FF, 0, 0);
    idle_cycle();
    cycle(1, 159, 119, 9'h0AA, 0, 0);
    check("corner_addr", 32'(mem_address), 19199);
    cycle(1, 10, 1, 9'h155, 0, 0);
    check("second_addr", 32'(mem_address), 170);
    cycle(1, 160, 5, 9'h011, 0, 0);
    cycle(1, 3, 120, 9'h022, 0, 0);
    idle_cycle();
    check("drop_two", 32'(drop_count), 2);

    random_plots(300);

    // Clear to 0 with 300 plots and a second clear_start during the sweep.
    busy_cycles = 0;
    clear_writes = 0;
    cycle(0, 0, 0, 0, 1, 9'h000);
    k = 0;
    while (m_busy && k < 20000) begin
      cycle(k < 300, $urandom_range(0, 159), $urandom_range(0, 119), $urandom_range(0, 511),
            k == 1000, $urandom_range(0, 511));
      k++;
    end
    check("clear_terminates", 32'(m_busy), 0);
    check("clear_busy_cycles", 32'(busy_cycles), NPIX);
    check("clear_writes", 32'(clear_writes), NPIX);
    check("drop_saturated", 32'(drop_count), 255);
    // Plot in the cycle right after clear_done is accepted.
    cycle(1, 7, 2, 9'h0F0, 0, 0);
    check("post_clear_wren", 32'(mem_wren), 1);

    random_plots(200);

    // Second clear with a random colour, interrupted by reset at address 5000.
    cycle(0, 0, 0, 0, 1, $urandom_range(1, 511));
    k = 0;
    while (m_cur < 5000 && k < 6000) begin
      cycle($urandom_range(0, 1), $urandom_range(0, 159), $urandom_range(0, 119), 0, 0, 0);
      k++;
    end
    check("reached_5000", 32'(mem_address), 5000);
    #1;
    reset = 1'b1;
    #1;
    check("midrst_wren", 32'(mem_wren), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_done", 32'(clear_done), 0);
    check("midrst_drop", 32'(drop_count), 0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    cycle(1, 1, 0, 9'h123, 0, 0);
    check("after_rst_addr", 32'(mem_address), 1);
    cycle(0, 0, 0, 0, 0, 0);
    check("after_rst_idle", 32'(clear_done), 0);

    random_plots(300);

    diffs = 0;
    for (int i = 0; i < NPIX; i++) begin
      if (fb_dut[i] != fb_ref[i]) diffs++;
    end
    check("framebuffer_diffs", 32'(diffs), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pixel_frame_writer.md
Name: pixel_frame_writer

Overview:
Receiving end of the pixel-plot stream that the draw blocks emit (x, y, colour, plot strobe), at 160x120 resolution with 9-bit colour. Translates each plotted coordinate to a linear address and issues a registered write into an external 19200x9 frame-buffer RAM. Also provides a full-screen clear that fills the buffer with a single colour. Drop accounting lets the draw FSMs and the bench detect lost pixels.

Parameters:
SCREEN_W, 160, pixels per row
SCREEN_H, 120, rows per frame
COLOUR_W, 9, colour width in bits
ADDR_W, 15, frame-buffer address width

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
plot  input  1  pixel valid strobe, one pixel per cycle
x  input  8  pixel column
y  input  7  pixel row
colour  input  COLOUR_W  pixel colour
clear_start  input  1  request full-buffer fill, sampled each cycle
clear_colour  input  COLOUR_W  fill colour, captured with clear_start
mem_address  output  ADDR_W  frame-buffer write address (registered)
mem_data  output  COLOUR_W  frame-buffer write data (registered)
mem_wren  output  1  frame-buffer write enable (registered)
busy  output  1  high while a clear is in progress
clear_done  output  1  one-cycle pulse at end of clear
drop_count  output  8  saturating count of discarded plots

Behaviour:
- Reset (asynchronous, active-high): all outputs 0, FSM to IDLE, clear counter 0, drop_count 0. Outputs stay 0 while reset is high.
- Address rule: addr = y*160 + x, computed as (y<<7)+(y<<5)+x with no multiplier. The result is 15 bits wide. The maximum is 19199.
- FSM states: IDLE, CLEAR.
- IDLE, plot=1, x<SCREEN_W, y<SCREEN_H:
  - Next cycle: mem_wren=1, mem_address=addr, mem_data=colour.
  - Latency is exactly 1 cycle, with a throughput of 1 pixel per cycle.
- IDLE, plot=1, coordinate out of range (x>=160 or y>=120):
  - No write; mem_wren=0 next cycle.
  - drop_count increments, saturating at 255.
- IDLE, plot=0: mem_wren=0 next cycle. mem_address and mem_data hold their last values.
- IDLE, clear_start=1:
  - Capture clear_colour and go to CLEAR. busy=1 from the next cycle.
  - A plot in the same cycle is discarded and counted as a drop. Clear has priority.
- CLEAR:
  - One write per cycle: mem_wren=1, mem_data=captured colour, mem_address=0,1,...,19199 consecutively.
  - The first write (addr 0) occurs in the first busy cycle.
  - Every plot seen while busy=1 is discarded and counted in drop_count.
  - clear_start while busy is ignored. Clear is not restarted.
- End of clear:
  - The cycle after the addr-19199 write: mem_wren=0, busy=0, clear_done=1 for exactly one cycle, FSM back to IDLE.
  - A plot in that same cycle is accepted normally.
- Reset mid-clear: writes stop immediately (mem_wren=0 asynchronously), busy=0, no clear_done pulse. Buffer contents are left partially cleared.
- drop_count clears only on reset and never wraps.

Test Plan:
- plot=1, x=0, y=0, colour=9'h1FF -> next cycle mem_wren=1, mem_address=0, mem_data=9'h1FF; the following cycle mem_wren=0.
- Back-to-back plots (159,119,9'h0AA) then (10,1,9'h155) -> consecutive write cycles at addresses 19199 then 170, with matching data.
- plot with x=160, y=5, then x=3, y=120 -> no mem_wren pulses; drop_count=2.
- clear_start=1, clear_colour=9'h000 -> 19200 consecutive writes at addresses 0..19199 with data 0; busy high for 19200 cycles; clear_done single pulse on cycle 19201; busy=0 that cycle.
- During a clear, 300 plot strobes and a second clear_start -> no extra writes, no restart, drop_count saturates at 255.
- Reset asserted mid-clear at address 5000 -> mem_wren, busy and clear_done 0 without a clock edge; after release, a plot at (1,0) writes to address 1 one cycle later.
